mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch/data clients, the arbiter and the memory port.
// The arbiter takes the slave view; the clients and memory model take the master view.
interface mem_arbiter_if;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_valid;
  logic [15:0] f_data;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [15:0] d_rdata;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_ack;
  logic [15:0] m_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output f_gnt, f_valid, f_data, d_gnt, d_valid, d_rdata, err,
           m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  f_gnt, f_valid, f_data, d_gnt, d_valid, d_rdata, err,
           m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: data wins by default, fetch is forced through after
// STARVE consecutive losses; each transaction aborts after TIMEOUT unacked BUSY cycles.
module mem_arbiter #(
  parameter int STARVE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] SKIP_MAX  = SW'(STARVE);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t        r_state;
  owner_t        r_owner;
  logic [SW-1:0] r_skip;
  logic [WW-1:0] r_wait;
  logic          r_m_req;
  logic          r_m_we;
  logic [15:0]   r_m_addr;
  logic [15:0]   r_m_wdata;
  logic          r_f_valid;
  logic          r_d_valid;
  logic          r_err;
  logic [15:0]   r_f_data;
  logic [15:0]   r_d_rdata;

  logic w_idle;
  logic w_data_win;
  logic w_fetch_win;

  // Grants are suppressed while reset is held so nothing is accepted mid-reset.
  assign w_idle      = (r_state == S_IDLE) && !rst;
  assign w_data_win  = bus.d_req && !(bus.f_req && (r_skip == SKIP_MAX));
  assign w_fetch_win = bus.f_req && !w_data_win;

  assign bus.d_gnt   = w_idle && w_data_win;
  assign bus.f_gnt   = w_idle && w_fetch_win;
  assign bus.m_req   = r_m_req;
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.f_valid = r_f_valid;
  assign bus.d_valid = r_d_valid;
  assign bus.err     = r_err;
  assign bus.f_data  = r_f_data;
  assign bus.d_rdata = r_d_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= OWN_FETCH;
      r_skip    <= '0;
      r_wait    <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_f_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_err     <= 1'b0;
      r_f_data  <= '0;
      r_d_rdata <= '0;
    end else begin
      r_f_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_data_win) begin
            r_state   <= S_BUSY;
            r_owner   <= OWN_DATA;
            r_m_req   <= 1'b1;
            r_m_we    <= bus.d_we;
            r_m_addr  <= bus.d_addr;
            r_m_wdata <= bus.d_wdata;
            r_wait    <= '0;
            if (!bus.f_req)
              r_skip <= '0;
            else if (r_skip != SKIP_MAX)
              r_skip <= r_skip + SW'(1);
          end else if (w_fetch_win) begin
            r_state   <= S_BUSY;
            r_owner   <= OWN_FETCH;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= bus.f_addr;
            r_m_wdata <= '0;
            r_wait    <= '0;
            r_skip    <= '0;
          end
        end
        S_BUSY: begin
          // An ack arriving in the last allowed cycle still completes normally.
          if (bus.m_ack) begin
            r_state <= S_IDLE;
            r_m_req <= 1'b0;
            if (r_owner == OWN_FETCH) begin
              r_f_valid <= 1'b1;
              r_f_data  <= bus.m_rdata;
            end else begin
              r_d_valid <= 1'b1;
              if (!r_m_we)
                r_d_rdata <= bus.m_rdata;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_state <= S_IDLE;
            r_m_req <= 1'b0;
            r_err   <= 1'b1;
            if (r_owner == OWN_FETCH) begin
              r_f_valid <= 1'b1;
              r_f_data  <= '0;
            end else begin
              r_d_valid <= 1'b1;
              r_d_rdata <= '0;
            end
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of grants, completions and timeouts.
module tb_mem_arbiter;
  localparam int STARVE  = 4;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE(STARVE), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit          md_busy;
  bit          md_own_data;
  bit          md_store;
  logic [15:0] md_addr;
  logic [15:0] md_wdata;
  int          md_cycles;
  int          md_skip;
  bit          md_gf;
  bit          md_gd;
  bit          e_fv;
  bit          e_dv;
  bit          e_err;
  logic [15:0] e_fdata;
  logic [15:0] e_drdata;
  bit          obs_fg;
  bit          obs_dg;

  task automatic model_reset();
    md_busy = 0; md_own_data = 0; md_store = 0; md_addr = '0; md_wdata = '0;
    md_cycles = 0; md_skip = 0; md_gf = 0; md_gd = 0;
    e_fv = 0; e_dv = 0; e_err = 0; e_fdata = '0; e_drdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.f_req = 0; bus.d_req = 0; bus.m_ack = 0;
    @(posedge clk); #1;
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_f_data", bus.f_data, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    model_reset();
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input bit fr, input logic [15:0] fa, input bit dr, input bit dwe,
                       input logic [15:0] da, input logic [15:0] dwd,
                       input bit ack, input logic [15:0] rd);
    bus.f_req = fr; bus.f_addr = fa;
    bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
    bus.m_ack = ack; bus.m_rdata = rd;
    @(negedge clk);
    md_gd = !md_busy && dr && !(fr && md_skip >= STARVE);
    md_gf = !md_busy && fr && !md_gd;
    obs_fg = bus.f_gnt;
    obs_dg = bus.d_gnt;
    chk("f_gnt", bus.f_gnt, md_gf);
    chk("d_gnt", bus.d_gnt, md_gd);
    chk("m_req", bus.m_req, md_busy);
    if (md_busy) begin
      chk("m_addr", bus.m_addr, md_addr);
      chk("m_we", bus.m_we, md_store);
      chk("m_wdata", bus.m_wdata, md_wdata);
    end
    chk("f_valid", bus.f_valid, e_fv);
    chk("d_valid", bus.d_valid, e_dv);
    chk("err", bus.err, e_err);
    chk("f_data", bus.f_data, e_fdata);
    chk("d_rdata", bus.d_rdata, e_drdata);

    e_fv = 0; e_dv = 0; e_err = 0;
    if (md_busy) begin
      md_cycles++;
      if (ack) begin
        md_busy = 0;
        if (md_own_data) begin
          e_dv = 1;
          if (!md_store) e_drdata = rd;
        end else begin
          e_fv = 1;
          e_fdata = rd;
        end
      end else if (md_cycles == TIMEOUT) begin
        md_busy = 0;
        e_err = 1;
        if (md_own_data) begin e_dv = 1; e_drdata = '0; end
        else begin e_fv = 1; e_fdata = '0; end
      end
    end else if (md_gd) begin
      md_busy = 1; md_own_data = 1; md_store = dwe; md_addr = da; md_wdata = dwd;
      md_cycles = 0;
      md_skip = fr ? ((md_skip + 1 > STARVE) ? STARVE : md_skip + 1) : 0;
    end else if (md_gf) begin
      md_busy = 1; md_own_data = 0; md_store = 0; md_addr = fa; md_wdata = '0;
      md_cycles = 0;
      md_skip = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [9:0]  seq;
    int          ng;
    bit          fr, dr, dwe;
    logic [15:0] fa, da, dwd;

    rst = 1'b1;
    bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.m_ack = 0; bus.m_rdata = '0;
    #2;
    chk("rst_f_valid", bus.f_valid, 0);
    chk("rst_err", bus.err, 0);
    do_reset();

    // Single fetch with ack in cycle 3
    cycle(1, 16'h0010, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    chk("fetch_gnt", obs_fg, 1);
    chk("fetch_maddr", bus.m_addr, 16'h0010);
    cycle(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    cycle(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    cycle(0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 16'h8A12);
    chk("fetch_valid", bus.f_valid, 1);
    chk("fetch_data", bus.f_data, 16'h8A12);

    // Load then store: store leaves d_rdata alone
    cycle(0, 16'h0, 1, 0, 16'h0100, 16'h0, 0, 16'h0);
    cycle(0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 16'h1234);
    cycle(0, 16'h0, 1, 1, 16'h0200, 16'hBEEF, 1, 16'h7777);
    chk("store_gnt", obs_dg, 1);
    chk("store_m_we", bus.m_we, 1);
    chk("store_m_wdata", bus.m_wdata, 16'hBEEF);
    cycle(0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 16'h5555);
    chk("store_valid", bus.d_valid, 1);
    chk("store_rdata_kept", bus.d_rdata, 16'h1234);

    // Starvation: both requesting, immediate acks
    do_reset();
    seq = '0;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 16'h0F00, 1, 0, 16'h0D00, 16'h0, 1, 16'hA5A5);
      if ((obs_fg || obs_dg) && ng < 10) begin
        seq = {seq[8:0], obs_dg};
        ng++;
      end
    end
    chk("starve_count", ng, 10);
    chk("starve_seq", seq, 10'b1111011110);

    // Timeout on a load: four unacked BUSY cycles
    cycle(0, 16'h0, 1, 0, 16'h0300, 16'h0, 0, 16'h0);
    chk("tmo_gnt", obs_dg, 1);
    for (int i = 0; i < TIMEOUT; i++)
      cycle(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    chk("tmo_d_valid", bus.d_valid, 1);
    chk("tmo_err", bus.err, 1);
    chk("tmo_d_rdata", bus.d_rdata, 16'h0000);
    cycle(1, 16'h0040, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    chk("tmo_next_gnt", obs_fg, 1);

    // Reset during BUSY with a fetch pending
    bus.f_req = 1; bus.f_addr = 16'h0444;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_m_req", bus.m_req, 0);
    chk("rst_busy_f_gnt", bus.f_gnt, 0);
    model_reset();
    @(posedge clk); #1;
    chk("rst_busy_f_valid", bus.f_valid, 0);
    chk("rst_busy_d_valid", bus.d_valid, 0);
    rst = 1'b0;
    cycle(1, 16'h0444, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    chk("rst_release_gnt", obs_fg, 1);
    cycle(0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 16'h3C3C);
    chk("rst_release_fdata", bus.f_data, 16'h3C3C);

    // Randomized traffic
    do_reset();
    fr = 0; dr = 0; dwe = 0; fa = '0; da = '0; dwd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!fr && $urandom_range(0, 2) != 0) begin
        fr = 1; fa = 16'($urandom);
      end
      if (!dr && $urandom_range(0, 2) != 0) begin
        dr = 1; dwe = 1'($urandom_range(0, 1)); da = 16'($urandom); dwd = 16'($urandom);
      end
      cycle(fr, fa, dr, dwe, da, dwd, ($urandom_range(0, 2) == 0), 16'($urandom));
      if (md_gf) fr = 0;
      if (md_gd) dr = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
